// File: rtl/aes_gcm_sched_pkg.sv
// Shared types and constants for the AES-GCM issue scheduler.
// J0 and counter-block helpers follow the 96-bit-IV form of GCM.
package aes_gcm_sched_pkg;

    localparam int BLK_W = 128;
    localparam int KS_W  = 1408;
    localparam int CNT_W = 16;

    localparam logic [31:0] GCM_J0_SUFFIX = 32'h1;

    typedef enum logic [1:0] {
        BEAT_AAD   = 2'd0,
        BEAT_PT    = 2'd1,
        BEAT_EMPTY = 2'd2
    } beat_type_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_AAD,
        ST_PT,
        ST_EMPTY,
        ST_DONE
    } state_e;

    // Increment only the low 32-bit word; the IV part never carries.
    function automatic logic [BLK_W-1:0] inc32(input logic [BLK_W-1:0] blk);
        return {blk[BLK_W-1:32], blk[31:0] + 32'd1};
    endfunction

endpackage

// File: rtl/aes_gcm_len_calc.sv
// Bit length of an AAD or PT field from its block count and the byte
// count of its last block (0 or >16 means a full block).
module aes_gcm_len_calc
    import aes_gcm_sched_pkg::*;
(
    input  logic [CNT_W-1:0] blocks,
    input  logic [4:0]       last_bytes,
    output logic [63:0]      bit_len
);

    logic [4:0] eff_bytes;

    always_comb begin
        eff_bytes = ((last_bytes == 5'd0) || (last_bytes > 5'd16)) ? 5'd16 : last_bytes;
        if (blocks == '0) begin
            bit_len = '0;
        end else begin
            bit_len = ({48'd0, blocks - CNT_W'(1)} << 7) + {56'd0, eff_bytes, 3'b000};
        end
    end

endmodule

// File: rtl/aes_gcm_issue_scheduler.sv
// Front-end sequencer: captures one GCM instance and issues one registered
// pipeline beat per accepted AAD/PT block (or a single EMPTY beat).
module aes_gcm_issue_scheduler
    import aes_gcm_sched_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_start,
    input  logic [95:0]       i_iv,
    input  logic [KS_W-1:0]   i_key_schedule,
    input  logic [CNT_W-1:0]  i_aad_blocks,
    input  logic [4:0]        i_aad_last_bytes,
    input  logic [CNT_W-1:0]  i_pt_blocks,
    input  logic [4:0]        i_pt_last_bytes,
    input  logic              i_data_valid,
    input  logic [BLK_W-1:0]  i_data,
    output logic              o_data_ready,
    output logic              o_valid,
    output logic              o_new_instance,
    output logic              o_last,
    output logic [1:0]        o_beat_type,
    output logic [BLK_W-1:0]  o_h,
    output logic [BLK_W-1:0]  o_encrypted_j0,
    output logic [BLK_W-1:0]  o_encrypted_cb,
    output logic [BLK_W-1:0]  o_plain_text,
    output logic [BLK_W-1:0]  o_aad,
    output logic [BLK_W-1:0]  o_instance_size,
    output logic [KS_W-1:0]   o_key_schedule,
    output logic              o_busy
);

    state_e             state_reg, state_next;
    logic [CNT_W-1:0]   aad_left_reg, pt_left_reg;
    logic [BLK_W-1:0]   cb_reg;
    logic               first_reg;
    logic               accept, issue, last_next, start_ok;
    beat_type_e         beat_type_next;

    logic [CNT_W-1:0]   len_blocks [2];
    logic [4:0]         len_bytes  [2];
    logic [63:0]        len_bits   [2];

    assign len_blocks[0] = i_aad_blocks;
    assign len_bytes[0]  = i_aad_last_bytes;
    assign len_blocks[1] = i_pt_blocks;
    assign len_bytes[1]  = i_pt_last_bytes;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_len
            aes_gcm_len_calc u_len (
                .blocks     (len_blocks[gi]),
                .last_bytes (len_bytes[gi]),
                .bit_len    (len_bits[gi])
            );
        end
    endgenerate

    assign o_data_ready = (state_reg == ST_AAD) || (state_reg == ST_PT);
    assign o_busy       = (state_reg != ST_IDLE);
    assign o_h          = '0;
    assign accept       = i_data_valid && o_data_ready;
    assign start_ok     = (state_reg == ST_IDLE) && i_start;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        issue          = 1'b0;
        last_next      = 1'b0;
        beat_type_next = BEAT_AAD;
        case (state_reg)
            ST_IDLE: begin
                if (i_start) begin
                    if (i_aad_blocks != '0)     state_next = ST_AAD;
                    else if (i_pt_blocks != '0) state_next = ST_PT;
                    else                        state_next = ST_EMPTY;
                end
            end
            ST_AAD: begin
                if (accept) begin
                    issue          = 1'b1;
                    beat_type_next = BEAT_AAD;
                    last_next      = (aad_left_reg == CNT_W'(1)) && (pt_left_reg == '0);
                    if (aad_left_reg == CNT_W'(1)) begin
                        state_next = (pt_left_reg != '0) ? ST_PT : ST_DONE;
                    end
                end
            end
            ST_PT: begin
                if (accept) begin
                    issue          = 1'b1;
                    beat_type_next = BEAT_PT;
                    last_next      = (pt_left_reg == CNT_W'(1));
                    if (pt_left_reg == CNT_W'(1)) state_next = ST_DONE;
                end
            end
            ST_EMPTY: begin
                issue          = 1'b1;
                beat_type_next = BEAT_EMPTY;
                last_next      = 1'b1;
                state_next     = ST_DONE;
            end
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aad_left_reg    <= '0;
            pt_left_reg     <= '0;
            cb_reg          <= '0;
            first_reg       <= 1'b0;
            o_valid         <= 1'b0;
            o_new_instance  <= 1'b0;
            o_last          <= 1'b0;
            o_beat_type     <= 2'd0;
            o_encrypted_j0  <= '0;
            o_encrypted_cb  <= '0;
            o_plain_text    <= '0;
            o_aad           <= '0;
            o_instance_size <= '0;
            o_key_schedule  <= '0;
        end else begin
            o_valid <= issue;
            if (start_ok) begin
                aad_left_reg    <= i_aad_blocks;
                pt_left_reg     <= i_pt_blocks;
                cb_reg          <= inc32({i_iv, GCM_J0_SUFFIX});
                first_reg       <= 1'b1;
                o_encrypted_j0  <= {i_iv, GCM_J0_SUFFIX};
                o_instance_size <= {len_bits[0], len_bits[1]};
                o_key_schedule  <= i_key_schedule;
            end
            if (issue) begin
                first_reg      <= 1'b0;
                o_new_instance <= first_reg;
                o_last         <= last_next;
                o_beat_type    <= beat_type_next;
                o_encrypted_cb <= cb_reg;
                o_plain_text   <= (beat_type_next == BEAT_PT)  ? i_data : '0;
                o_aad          <= (beat_type_next == BEAT_AAD) ? i_data : '0;
            end else begin
                o_new_instance <= 1'b0;
                o_last         <= 1'b0;
            end
            // The PT beat carries the pre-increment counter; the next PT beat sees +1.
            if (accept && (state_reg == ST_AAD)) aad_left_reg <= aad_left_reg - CNT_W'(1);
            if (accept && (state_reg == ST_PT)) begin
                pt_left_reg <= pt_left_reg - CNT_W'(1);
                cb_reg      <= inc32(cb_reg);
            end
        end
    end

endmodule

// File: tb/tb_aes_gcm_issue_scheduler.sv
// Self-checking bench: table-driven and randomized instances checked against
// a queue-based beat model, plus a mid-instance reset sequence.
module tb_aes_gcm_issue_scheduler;
    import aes_gcm_sched_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              i_start;
    logic [95:0]       i_iv;
    logic [KS_W-1:0]   i_key_schedule;
    logic [CNT_W-1:0]  i_aad_blocks;
    logic [4:0]        i_aad_last_bytes;
    logic [CNT_W-1:0]  i_pt_blocks;
    logic [4:0]        i_pt_last_bytes;
    logic              i_data_valid;
    logic [BLK_W-1:0]  i_data;
    logic              o_data_ready, o_valid, o_new_instance, o_last, o_busy;
    logic [1:0]        o_beat_type;
    logic [BLK_W-1:0]  o_h, o_encrypted_j0, o_encrypted_cb, o_plain_text, o_aad, o_instance_size;
    logic [KS_W-1:0]   o_key_schedule;

    always #5 clk = ~clk;

    aes_gcm_issue_scheduler dut (
        .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_iv(i_iv),
        .i_key_schedule(i_key_schedule), .i_aad_blocks(i_aad_blocks),
        .i_aad_last_bytes(i_aad_last_bytes), .i_pt_blocks(i_pt_blocks),
        .i_pt_last_bytes(i_pt_last_bytes), .i_data_valid(i_data_valid), .i_data(i_data),
        .o_data_ready(o_data_ready), .o_valid(o_valid), .o_new_instance(o_new_instance),
        .o_last(o_last), .o_beat_type(o_beat_type), .o_h(o_h),
        .o_encrypted_j0(o_encrypted_j0), .o_encrypted_cb(o_encrypted_cb),
        .o_plain_text(o_plain_text), .o_aad(o_aad), .o_instance_size(o_instance_size),
        .o_key_schedule(o_key_schedule), .o_busy(o_busy)
    );

    typedef struct {
        logic [1:0]   btype;
        logic         first;
        logic         last;
        logic [127:0] cb;
        logic [127:0] pt;
        logic [127:0] aad;
    } beat_t;

    typedef struct {
        logic [95:0] iv;
        int          aad_n, aad_lb, pt_n, pt_lb, mode, stray;
        logic [63:0] len_a, len_c;
    } vec_t;

    beat_t            exp_q[$];
    beat_t            mon_b;
    vec_t             vecs[6];
    int               n_checks = 0;
    int               n_fail   = 0;
    int               beats_seen = 0;
    int               inst_id = 0;
    logic [127:0]     cur_j0, cur_size;
    logic [KS_W-1:0]  cur_key;
    logic [127:0]     blk_mem[64];

    function automatic void chk(string name, logic [127:0] act, logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (instance %0d): got %h required %h", name, inst_id, act, exp);
        end
    endfunction

    function automatic logic [63:0] model_len(int n, int lb);
        int eff;
        eff = (lb == 0 || lb > 16) ? 16 : lb;
        if (n == 0) return 64'd0;
        return 64'(n) * 64'd128 - 64'(16 - eff) * 64'd8;
    endfunction

    function automatic logic [127:0] rand_blk();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    always @(negedge clk) begin
        if (rst_n && o_valid) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_beat (instance %0d): got beat type %0d required none", inst_id, o_beat_type);
            end else begin
                mon_b = exp_q.pop_front();
                beats_seen++;
                $display("beat inst=%0d type=%0d new=%0b last=%0b cb=%h", inst_id, o_beat_type, o_new_instance, o_last, o_encrypted_cb);
                chk("beat_type", 128'(o_beat_type), 128'(mon_b.btype));
                chk("new_instance", 128'(o_new_instance), 128'(mon_b.first));
                chk("last", 128'(o_last), 128'(mon_b.last));
                chk("cb", o_encrypted_cb, mon_b.cb);
                chk("plain_text", o_plain_text, mon_b.pt);
                chk("aad", o_aad, mon_b.aad);
                chk("j0", o_encrypted_j0, cur_j0);
                chk("instance_size", o_instance_size, cur_size);
                chk("h", o_h, 128'd0);
                chk("key_schedule", 128'(o_key_schedule == cur_key), 128'd1);
                chk("busy_on_beat", 128'(o_busy), 128'd1);
            end
        end
    end

    task automatic run_instance(input logic [95:0] iv, input int aad_n, input int aad_lb,
                                input int pt_n, input int pt_lb, input int mode, input int stray,
                                input logic [63:0] len_a, input logic [63:0] len_c);
        int total, idx, cyc, exp_beats;
        logic v, rdy, seen_last;
        logic [KS_W-1:0] key;
        cyc = 0;
        while (o_busy && cyc < 100) begin @(negedge clk); cyc++; end
        chk("idle_before_start", 128'(o_busy), 128'd0);
        inst_id++;
        total = aad_n + pt_n;
        for (int i = 0; i < total; i++) blk_mem[i] = rand_blk();
        for (int w = 0; w < KS_W / 32; w++) key[w*32 +: 32] = $urandom;
        cur_j0 = {iv, 32'h1};
        cur_size = {len_a, len_c};
        cur_key = key;
        beats_seen = 0;
        for (int i = 0; i < aad_n; i++)
            exp_q.push_back('{2'd0, i == 0, (i == aad_n - 1) && (pt_n == 0), {iv, 32'd2}, 128'd0, blk_mem[i]});
        for (int j = 0; j < pt_n; j++)
            exp_q.push_back('{2'd1, (aad_n == 0) && (j == 0), j == pt_n - 1, {iv, 32'(2 + j)}, blk_mem[aad_n + j], 128'd0});
        if (total == 0) exp_q.push_back('{2'd2, 1'b1, 1'b1, {iv, 32'd2}, 128'd0, 128'd0});
        exp_beats = (total == 0) ? 1 : total;

        i_iv = iv; i_key_schedule = key;
        i_aad_blocks = 16'(aad_n); i_aad_last_bytes = 5'(aad_lb);
        i_pt_blocks = 16'(pt_n);   i_pt_last_bytes = 5'(pt_lb);
        i_start = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
        chk("busy_after_start", 128'(o_busy), 128'd1);

        idx = 0; cyc = 0;
        while (idx < total && cyc < 400) begin
            case (mode)
                0:       v = 1'b1;
                1:       v = (cyc % 2 == 0);
                default: v = 1'($urandom_range(0, 1));
            endcase
            i_data_valid = v;
            i_data = v ? blk_mem[idx] : rand_blk();
            if (stray != 0 && cyc == 1) begin
                i_start = 1'b1; i_iv = ~iv; i_key_schedule = ~key;
                i_aad_blocks = 16'd3; i_pt_blocks = 16'd7;
            end
            @(negedge clk); rdy = o_data_ready;
            @(posedge clk); #1;
            i_start = 1'b0;
            if (v && rdy) idx++;
            cyc++;
        end
        i_data_valid = 1'b0;
        chk("all_blocks_accepted", 128'(idx), 128'(total));

        cyc = 0; seen_last = 1'b0;
        while (!seen_last && cyc < 50) begin
            @(negedge clk);
            if (o_valid && o_last) seen_last = 1'b1;
            cyc++;
        end
        chk("last_seen", 128'(seen_last), 128'd1);
        @(negedge clk);
        chk("busy_drop", 128'(o_busy), 128'd0);
        chk("valid_idle", 128'(o_valid), 128'd0);
        chk("beat_count", 128'(beats_seen), 128'(exp_beats));
        chk("queue_drained", 128'(exp_q.size()), 128'd0);
        exp_q.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, a_n, a_lb, p_n, p_lb;
        logic [95:0] riv;
        vecs[0] = '{96'hCAFEBABE_FACEDBAD_DECAF888, 1, 16, 2, 16, 0, 0, 64'd128, 64'd256};
        vecs[1] = '{96'h0123_4567_89AB_CDEF_0011_2233, 0, 16, 0, 16, 0, 0, 64'd0, 64'd0};
        vecs[2] = '{96'hA5A5_A5A5_5A5A_5A5A_0F0F_0F0F, 0, 16, 3, 5, 1, 0, 64'd0, 64'd296};
        vecs[3] = '{96'h1111_2222_3333_4444_5555_6666, 2, 0, 1, 20, 2, 1, 64'd256, 64'd128};
        vecs[4] = '{96'hDEAD_BEEF_0000_0001_FFFF_FFFF, 3, 1, 0, 16, 1, 0, 64'd264, 64'd0};
        vecs[5] = '{96'h7777_8888_9999_AAAA_BBBB_CCCC, 1, 16, 1, 1, 0, 0, 64'd128, 64'd8};

        rst_n = 1'b0; i_start = 1'b0; i_iv = '0; i_key_schedule = '0;
        i_aad_blocks = '0; i_aad_last_bytes = '0; i_pt_blocks = '0; i_pt_last_bytes = '0;
        i_data_valid = 1'b0; i_data = '0;
        #12;
        chk("rst_valid", 128'(o_valid), 128'd0);
        chk("rst_busy", 128'(o_busy), 128'd0);
        chk("rst_ready", 128'(o_data_ready), 128'd0);
        chk("rst_j0", o_encrypted_j0, 128'd0);
        chk("rst_size", o_instance_size, 128'd0);
        chk("rst_key", 128'(o_key_schedule == '0), 128'd1);
        @(negedge clk); rst_n = 1'b1;

        // Back-to-back: each run starts in the first IDLE cycle after the previous one.
        foreach (vecs[k])
            run_instance(vecs[k].iv, vecs[k].aad_n, vecs[k].aad_lb, vecs[k].pt_n, vecs[k].pt_lb,
                         vecs[k].mode, vecs[k].stray, vecs[k].len_a, vecs[k].len_c);

        for (int r = 0; r < 10; r++) begin
            riv  = {$urandom, $urandom, $urandom};
            a_n  = $urandom_range(0, 3); a_lb = $urandom_range(0, 20);
            p_n  = $urandom_range(0, 4); p_lb = $urandom_range(0, 20);
            run_instance(riv, a_n, a_lb, p_n, p_lb, $urandom_range(0, 2), $urandom_range(0, 1),
                         model_len(a_n, a_lb), model_len(p_n, p_lb));
        end

        // Reset after the first of four PT beats aborts the stream.
        inst_id++;
        i_iv = 96'hFEED_FACE_0BAD_F00D_1234_5678; i_key_schedule = '1;
        i_aad_blocks = 16'd0; i_pt_blocks = 16'd4; i_pt_last_bytes = 5'd16;
        i_start = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0; i_data_valid = 1'b1; i_data = rand_blk();
        cyc = 0;
        while (!o_valid && cyc < 20) begin @(posedge clk); #1; cyc++; end
        chk("reset_seq_first_beat", 128'(o_valid), 128'd1);
        #2; rst_n = 1'b0; #1;
        chk("async_rst_valid", 128'(o_valid), 128'd0);
        chk("async_rst_busy", 128'(o_busy), 128'd0);
        chk("async_rst_last", 128'(o_last), 128'd0);
        chk("async_rst_j0", o_encrypted_j0, 128'd0);
        i_data_valid = 1'b0;
        @(negedge clk); @(negedge clk);
        chk("rst_hold_valid", 128'(o_valid), 128'd0);
        exp_q.delete();
        rst_n = 1'b1;
        run_instance(96'hFEED_FACE_0BAD_F00D_1234_5678, 0, 16, 2, 16, 0, 0, 64'd0, 64'd256);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
